ddr_stream_reader: RTL and testbench

- Burst-read client for one requester port of the 4-way DDR arbiter.
- Given a start word address and a word count, it acquires the DDR port, issues burst reads and buffers returned words in an internal FIFO.
- Presents the words as a valid/ready stream to consumers such as video line fetch or audio sample streaming.
- Holds the arbiter grant via acquire for the whole transfer, including draining of in-flight words.

---
 rtl/ddr_stream_reader.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ddr_stream_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_stream_reader.sv
// -----------------------------------------------------------------------------
// ddr_stream_reader
//
// Burst-read client for one requester port of the 4-way DDR arbiter.
//
// A transfer is described by a start word address and a word count. The reader
// does the following:
//   - acquires the DDR port;
//   - issues one burst read at a time, each no larger than BURST words;
//   - buffers the returned words in a first-word-fall-through FIFO;
//   - presents the words as a valid/ready stream.
//
// A new burst is only requested when the FIFO has room for every word that is
// already buffered or in flight, plus the new burst. The FIFO therefore cannot
// overflow, even when the consumer stalls.
//
// abort stops issuing bursts and flushes the FIFO. It keeps the port acquired
// until every word still in flight has come back, and those words are
// discarded.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   start              begin a transfer (accepted only while busy=0)
//   start_addr         first 64-bit word address
//   length             number of words to read (0 = no transfer)
//   abort              cancel the current transfer
//   busy               transfer or drain in progress
//   out_data           stream word (valid together with out_valid)
//   out_valid          FIFO not empty
//   out_ready          consumer accepts the current word
//   ddr_addr           burst start address      -> ddr_if.addr
//   ddr_read           read request             -> ddr_if.read
//   ddr_write          tied 0                   -> ddr_if.write
//   ddr_wdata          tied 0                   -> ddr_if.wdata
//   ddr_burstcnt       words in this burst      -> ddr_if.burstcnt
//   ddr_byteenable     tied 8'hFF               -> ddr_if.byteenable
//   ddr_acquire        hold arbiter grant       -> ddr_if.acquire
//   ddr_busy           waitrequest              <- ddr_if.busy
//   ddr_rdata          returned read word       <- ddr_if.rdata
//   ddr_rdata_ready    one pulse per word       <- ddr_if.rdata_ready
// -----------------------------------------------------------------------------
module ddr_stream_reader #(
    parameter int BURST      = 16,  // max words per burst, 1..128, power of two
    parameter int FIFO_DEPTH = 64   // FIFO words, power of two, >= 2*BURST
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        start,
    input  logic [28:0] start_addr,
    input  logic [23:0] length,
    input  logic        abort,
    output logic        busy,

    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,

    output logic [28:0] ddr_addr,
    output logic        ddr_read,
    output logic        ddr_write,
    output logic [63:0] ddr_wdata,
    output logic [7:0]  ddr_burstcnt,
    output logic [7:0]  ddr_byteenable,
    output logic        ddr_acquire,
    input  logic        ddr_busy,
    input  logic [63:0] ddr_rdata,
    input  logic        ddr_rdata_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_q,        state_d;
    logic [23:0]     remaining_q,    remaining_d;     // words not yet requested
    logic [8:0]      outstanding_q,  outstanding_d;   // requested, not returned
    logic [28:0]     next_addr_q,    next_addr_d;     // wraps modulo 2^29
    logic            discard_q,      discard_d;       // aborted: drop returns
    logic [28:0]     ddr_addr_q,     ddr_addr_d;
    logic [7:0]      ddr_burstcnt_q, ddr_burstcnt_d;
    logic [AW-1:0]   wr_ptr_q,       wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,       rd_ptr_d;
    logic [CW-1:0]   count_q,        count_d;

    logic [63:0]     mem_q [FIFO_DEPTH];

    // -------------------------------------------------------------------------
    // Intermediate combinational terms
    // -------------------------------------------------------------------------
    logic [7:0]      burst;          // min(BURST, remaining)
    logic [31:0]     free_words;     // FIFO space not yet spoken for
    logic            space_ok;
    logic            handshake;      // DDR accepts the read this cycle
    logic            accept_word;    // a returned word belongs to our burst
    logic            abort_now;
    logic            fifo_push;
    logic            fifo_pop;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_d        = state_q;
        remaining_d    = remaining_q;
        outstanding_d  = outstanding_q;
        next_addr_d    = next_addr_q;
        discard_d      = discard_q;
        ddr_addr_d     = ddr_addr_q;
        ddr_burstcnt_d = ddr_burstcnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;

        burst      = (remaining_q < 24'(BURST)) ? remaining_q[7:0] : 8'(BURST);
        // In-flight words already have FIFO slots reserved for them.
        free_words = 32'(FIFO_DEPTH) - 32'(count_q) - 32'(outstanding_q);
        space_ok   = (free_words >= 32'(burst));

        handshake  = (state_q == ST_REQ) && !ddr_busy;
        // Outstanding is still 0 in the handshake cycle, but the first word
        // of the burst may already arrive in that same cycle.
        accept_word = ddr_rdata_ready && ((outstanding_q != 9'd0) || handshake);
        abort_now   = abort && (state_q != ST_IDLE);
        fifo_push   = accept_word && !discard_q && !abort_now;
        fifo_pop    = (count_q != '0) && out_ready;

        // ---------------------------------------------------------------------
        // Request bookkeeping
        // ---------------------------------------------------------------------
        if (handshake) begin
            remaining_d   = remaining_q - 24'(burst);
            next_addr_d   = next_addr_q + 29'(burst);
            outstanding_d = outstanding_d + 9'(burst);
        end
        if (accept_word) begin
            outstanding_d = outstanding_d - 9'd1;
        end

        // ---------------------------------------------------------------------
        // FIFO pointers. A simultaneous push and pop leave the count unchanged.
        // ---------------------------------------------------------------------
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);

        // ---------------------------------------------------------------------
        // Transfer sequencing
        // ---------------------------------------------------------------------
        case (state_q)
            ST_IDLE: begin
                if (start && (length != 24'd0)) begin
                    remaining_d = length;
                    next_addr_d = start_addr;
                    discard_d   = 1'b0;
                    state_d     = ST_ACQ;
                end
            end

            ST_ACQ: begin
                // Address and size are captured here and held stable on the
                // port until the DDR side accepts the request.
                if (space_ok) begin
                    ddr_addr_d     = next_addr_q;
                    ddr_burstcnt_d = burst;
                    state_d        = ST_REQ;
                end
            end

            ST_REQ: begin
                if (handshake) begin
                    // A one-word burst may complete in its own handshake cycle.
                    if (outstanding_d != 9'd0) begin
                        state_d = ST_WAIT;
                    end else if (remaining_d != 24'd0) begin
                        state_d = ST_ACQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_WAIT: begin
                if (outstanding_d == 9'd0) begin
                    if (discard_q) begin
                        state_d = ST_IDLE;
                    end else if (remaining_q != 24'd0) begin
                        state_d = ST_ACQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ---------------------------------------------------------------------
        // abort overrides sequencing.
        // - A burst the DDR side accepted in this very cycle is still counted,
        //   because its words will come back and must be absorbed.
        // - A request that has not been accepted simply disappears.
        // ---------------------------------------------------------------------
        if (abort_now) begin
            remaining_d = 24'd0;
            discard_d   = 1'b1;
            rd_ptr_d    = wr_ptr_q;
            count_d     = '0;
            state_d     = (outstanding_d != 9'd0) ? ST_WAIT : ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            outstanding_q  <= '0;
            next_addr_q    <= '0;
            discard_q      <= 1'b0;
            ddr_addr_q     <= '0;
            ddr_burstcnt_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            outstanding_q  <= outstanding_d;
            next_addr_q    <= next_addr_d;
            discard_q      <= discard_d;
            ddr_addr_q     <= ddr_addr_d;
            ddr_burstcnt_q <= ddr_burstcnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // NOTE: the storage array has no reset. Its contents are never observed
    // unless count_q says a slot holds a word, so clearing it would only cost
    // logic and prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= ddr_rdata;
        end
    end

    // The reservation scheme guarantees a returned word always has a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && (count_q == CW'(FIFO_DEPTH))));

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy           = (state_q != ST_IDLE);
    assign ddr_acquire    = (state_q == ST_ACQ) || (state_q == ST_REQ) ||
                            (state_q == ST_WAIT);
    assign ddr_read       = (state_q == ST_REQ);
    assign ddr_addr       = ddr_addr_q;
    assign ddr_burstcnt   = ddr_burstcnt_q;
    assign ddr_write      = 1'b0;
    assign ddr_wdata      = 64'd0;
    assign ddr_byteenable = 8'hFF;

    // First-word fall-through: the head word is visible whenever the FIFO
    // holds something.
    assign out_valid      = (count_q != '0);
    assign out_data       = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ddr_stream_reader.sv
// -----------------------------------------------------------------------------
// Directed testbench for ddr_stream_reader.
//
// A small DDR port model does three things:
//   - answers read requests after a programmable number of waitrequest cycles;
//   - logs every accepted burst;
//   - returns one word per cycle, starting one cycle after acceptance.
//
// Each returned word is derived from its address. A stream monitor collects
// every word the consumer accepts.
// -----------------------------------------------------------------------------
module tb_ddr_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [28:0] start_addr = '0;
    logic [23:0] length = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic        busy;
    logic [63:0] out_data;
    logic        out_valid;
    logic [28:0] ddr_addr;
    logic        ddr_read;
    logic        ddr_write;
    logic [63:0] ddr_wdata;
    logic [7:0]  ddr_burstcnt;
    logic [7:0]  ddr_byteenable;
    logic        ddr_acquire;
    logic        ddr_busy = 1'b1;
    logic [63:0] ddr_rdata = '0;
    logic        ddr_rdata_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // DDR model controls and logs
    int          grant_delay = 1;
    bit          deliver_en = 1'b1;
    int          pulses = 0;
    int          wait_cnt = 0;
    logic [28:0] pend_q[$];
    logic [28:0] hs_addr[$];
    logic [7:0]  hs_cnt[$];
    logic [63:0] got_q[$];

    ddr_stream_reader #(.BURST(16), .FIFO_DEPTH(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_addr      (start_addr),
        .length          (length),
        .abort           (abort),
        .busy            (busy),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .ddr_addr        (ddr_addr),
        .ddr_read        (ddr_read),
        .ddr_write       (ddr_write),
        .ddr_wdata       (ddr_wdata),
        .ddr_burstcnt    (ddr_burstcnt),
        .ddr_byteenable  (ddr_byteenable),
        .ddr_acquire     (ddr_acquire),
        .ddr_busy        (ddr_busy),
        .ddr_rdata       (ddr_rdata),
        .ddr_rdata_ready (ddr_rdata_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ddr_word(input logic [28:0] a);
        return {3'b101, a, 3'b011, ~a};
    endfunction

    // DDR port model. It acts on the falling edge so the DUT samples stable
    // values on the next rising edge.
    always @(negedge clk) begin
        ddr_rdata_ready = 1'b0;
        if (reset) begin
            pend_q.delete();
            wait_cnt = 0;
            ddr_busy = 1'b1;
        end else begin
            if (deliver_en && (pend_q.size() > 0)) begin
                ddr_rdata       = ddr_word(pend_q.pop_front());
                ddr_rdata_ready = 1'b1;
                pulses++;
            end
            if (ddr_read === 1'b1) begin
                if (wait_cnt < grant_delay) begin
                    ddr_busy = 1'b1;
                    wait_cnt++;
                end else begin
                    // Grant: the DUT handshakes on the coming rising edge.
                    ddr_busy = 1'b0;
                    wait_cnt = 0;
                    hs_addr.push_back(ddr_addr);
                    hs_cnt.push_back(ddr_burstcnt);
                    for (int k = 0; k < int'(ddr_burstcnt); k++) begin
                        pend_q.push_back(ddr_addr + 29'(k));
                    end
                end
            end else begin
                ddr_busy = 1'b1;
                wait_cnt = 0;
            end
        end
    end

    // Stream monitor: a word is consumed on the rising edge after this sample.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back(out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        hs_addr.delete();
        hs_cnt.delete();
    endtask

    task automatic start_xfer(input logic [28:0] a, input logic [23:0] l);
        start_addr = a;
        length     = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_read(input string tag, input int budget);
        int n = 0;
        while (ddr_read !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(ddr_read), 64'd1);
    endtask

    task automatic wait_bursts(input string tag, input int nb, input int budget);
        int n = 0;
        while (hs_addr.size() < nb && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(hs_addr.size()), 64'(nb));
    endtask

    task automatic check_stream(input string tag, input logic [28:0] base, input int len);
        logic [28:0] a;
        check({tag, "_count"}, 64'(got_q.size()), 64'(len));
        for (int i = 0; i < got_q.size() && i < len; i++) begin
            a = base + 29'(i);
            check($sformatf("%s[%0d]", tag, i), got_q[i], ddr_word(a));
        end
    endtask

    initial begin
        logic [28:0] a_hold;
        logic [7:0]  c_hold;
        int          stable_bad;
        int          p0;
        int          viol;
        int          n;

        // ---------------- reset state ----------------
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_busy",      64'(busy),           64'd0);
        check("rst_out_valid", 64'(out_valid),      64'd0);
        check("rst_read",      64'(ddr_read),       64'd0);
        check("rst_acquire",   64'(ddr_acquire),    64'd0);
        check("rst_addr",      64'(ddr_addr),       64'd0);
        check("rst_burstcnt",  64'(ddr_burstcnt),   64'd0);
        check("rst_write",     64'(ddr_write),      64'd0);
        check("rst_wdata",     ddr_wdata,           64'd0);
        check("rst_byteen",    64'(ddr_byteenable), 64'hFF);

        // ---------------- length 40: bursts 16,16,8 ----------------
        clear_logs();
        out_ready = 1'b1;
        start_xfer(29'h100, 24'd40);
        check("t1_busy_on",    64'(busy),        64'd1);
        check("t1_acquire_on", 64'(ddr_acquire), 64'd1);
        wait_idle("t1_done", 500);
        check("t1_acquire_off", 64'(ddr_acquire), 64'd0);
        check("t1_nbursts",     64'(hs_addr.size()), 64'd3);
        if (hs_addr.size() == 3) begin
            check("t1_addr0", 64'(hs_addr[0]), 64'h100);
            check("t1_addr1", 64'(hs_addr[1]), 64'h110);
            check("t1_addr2", 64'(hs_addr[2]), 64'h120);
            check("t1_cnt0",  64'(hs_cnt[0]),  64'd16);
            check("t1_cnt1",  64'(hs_cnt[1]),  64'd16);
            check("t1_cnt2",  64'(hs_cnt[2]),  64'd8);
        end
        check_stream("t1_word", 29'h100, 40);

        // ---------------- waitrequest held for 5 cycles ----------------
        clear_logs();
        grant_delay = 5;
        start_xfer(29'h200, 24'd16);
        wait_read("t2_read", 50);
        a_hold     = ddr_addr;
        c_hold     = ddr_burstcnt;
        stable_bad = 0;
        repeat (4) begin
            step();
            if (ddr_read !== 1'b1 || ddr_addr !== a_hold || ddr_burstcnt !== c_hold) begin
                stable_bad++;
            end
        end
        check("t2_stable",   64'(stable_bad), 64'd0);
        check("t2_hold_addr", 64'(a_hold),    64'h200);
        check("t2_hold_cnt",  64'(c_hold),    64'd16);
        wait_idle("t2_done", 500);
        check("t2_nbursts", 64'(hs_addr.size()), 64'd1);
        check_stream("t2_word", 29'h200, 16);
        grant_delay = 1;

        // ---------------- consumer stalled, length 200 ----------------
        clear_logs();
        out_ready = 1'b0;
        start_xfer(29'h1000, 24'd200);
        repeat (150) step();
        check("t3_nbursts_stall", 64'(hs_addr.size()), 64'd4);
        check("t3_read_stall",    64'(ddr_read),       64'd0);
        check("t3_acq_stall",     64'(ddr_acquire),    64'd1);
        check("t3_valid_stall",   64'(out_valid),      64'd1);
        out_ready = 1'b1;
        wait_idle("t3_done", 3000);
        check("t3_nbursts", 64'(hs_addr.size()), 64'd13);
        if (hs_addr.size() == 13) begin
            check("t3_last_addr", 64'(hs_addr[12]), 64'h10C0);
            check("t3_last_cnt",  64'(hs_cnt[12]),  64'd8);
        end
        check_stream("t3_word", 29'h1000, 200);

        // ---------------- abort in WAIT with 10 words outstanding ----------------
        clear_logs();
        out_ready = 1'b0;
        start_xfer(29'h3000, 24'd26);
        wait_bursts("t4_second_burst", 2, 200);
        deliver_en = 1'b0;
        step();
        check("t4_valid_pre", 64'(out_valid), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_valid_flush", 64'(out_valid),   64'd0);
        check("t4_acq_held",    64'(ddr_acquire), 64'd1);
        check("t4_busy_held",   64'(busy),        64'd1);
        out_ready  = 1'b1;
        p0         = pulses;
        deliver_en = 1'b1;
        viol       = 0;
        n          = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
            if (ddr_acquire === 1'b0 && (pulses - p0) < 10) begin
                viol++;
            end
        end
        check("t4_done",       64'(busy),           64'd0);
        check("t4_early_drop", 64'(viol),           64'd0);
        check("t4_pulses",     64'(pulses - p0),    64'd10);
        check("t4_no_words",   64'(got_q.size()),   64'd0);
        check("t4_acq_off",    64'(ddr_acquire),    64'd0);
        check("t4_nbursts",    64'(hs_addr.size()), 64'd2);

        // ---------------- abort with a request not yet accepted ----------------
        clear_logs();
        grant_delay = 100;
        start_xfer(29'h4000, 24'd16);
        wait_read("t5_read", 50);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_read_drop", 64'(ddr_read),       64'd0);
        check("t5_acq_drop",  64'(ddr_acquire),    64'd0);
        check("t5_busy",      64'(busy),           64'd0);
        check("t5_nbursts",   64'(hs_addr.size()), 64'd0);
        grant_delay = 1;

        // ---------------- address wrap ----------------
        clear_logs();
        start_xfer(29'h1FFFFFF8, 24'd16);
        wait_idle("t6_done", 500);
        check("t6_nbursts", 64'(hs_addr.size()), 64'd1);
        if (hs_addr.size() == 1) begin
            check("t6_addr", 64'(hs_addr[0]), 64'h1FFFFFF8);
            check("t6_cnt",  64'(hs_cnt[0]),  64'd16);
        end
        check_stream("t6_word", 29'h1FFFFFF8, 16);

        // ---------------- zero length ----------------
        clear_logs();
        start_xfer(29'h5000, 24'd0);
        check("t7_busy", 64'(busy),        64'd0);
        check("t7_acq",  64'(ddr_acquire), 64'd0);
        step();
        check("t7_busy_later", 64'(busy),           64'd0);
        check("t7_nbursts",    64'(hs_addr.size()), 64'd0);

        // ---------------- reset while requesting ----------------
        clear_logs();
        grant_delay = 100;
        start_xfer(29'h6000, 24'd16);
        wait_read("t8_read", 50);
        reset = 1'b1;
        step();
        check("t8_read", 64'(ddr_read),    64'd0);
        check("t8_acq",  64'(ddr_acquire), 64'd0);
        check("t8_busy", 64'(busy),        64'd0);
        reset = 1'b0;
        step();
        check("t8_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
